redmule_tcdm_splitter: RTL and testbench
========================================

Name: redmule_tcdm_splitter

Overview:
Sequential successor to the combinational wide-to-narrow TCDM split at the RedMulE boundary. It accepts one DW-bit hci_core-style request stream from the streamer and issues it on MP independent DW/MP-bit TCDM ports. Unlike a plain split, it tolerates per-port grant skew and response skew by tracking partial grants and buffering per-port responses. It sits between the redmule_top tcdm master and the cluster interconnect.

Parameters:
DW, 256, wide-side data width in bits; must be a multiple of MP*8
MP, 8, number of narrow TCDM ports; must be at least 1
AW, 32, address width
RESP_DEPTH, 2, maximum outstanding wide transactions; also the per-port response FIFO depth; must be at least 1
SKIP_ZERO_BE, 1, if 1, write slices with an all-zero byte-enable are not issued

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wide_req_i  in  1  wide request
wide_gnt_o  out  1  wide grant
wide_add_i  in  AW  wide byte address
wide_wen_i  in  1  1 = read, 0 = write
wide_be_i  in  DW/8  wide byte enable
wide_data_i  in  DW  wide write data
wide_r_data_o  out  DW  reassembled read data; slice i comes from port i
wide_r_valid_o  out  1  wide response valid
tcdm_req_o  out  MP  per-port request
tcdm_gnt_i  in  MP  per-port grant
tcdm_add_o  out  MP*AW  per-port address = wide_add_i + i*(DW/MP/8)
tcdm_wen_o  out  MP  per-port wen (copy of wide)
tcdm_be_o  out  MP*DW/(MP*8)  per-port byte-enable slice i
tcdm_data_o  out  MP*DW/MP  per-port data slice i
tcdm_r_data_i  in  MP*DW/MP  per-port read data
tcdm_r_valid_i  in  MP  per-port response valid; one per granted request, for reads and writes
busy_o  out  1  high while outstanding_q != 0 or any done_q bit is set

Behaviour:
- Reset (async, rst_ni=0): done_q=0, outstanding_q=0, all FIFOs empty. Outputs: tcdm_req_o=0, wide_gnt_o=0, wide_r_valid_o=0, busy_o=0, wide_r_data_o=0.
- Reset asserted mid-transaction discards in-flight state. Late tcdm_r_valid_i after reset release is a system error; it is not required to be handled.
- Wide-side protocol: the requester holds req, add, wen, be and data stable from req assertion until wide_gnt_o.
- credit_ok = (outstanding_q < RESP_DEPTH).
- skip[i] = SKIP_ZERO_BE & ~wide_wen_i & (be slice i == 0).
- tcdm_req_o[i] = wide_req_i & credit_ok & ~done_q[i] & ~skip[i]. This is combinational.
- A port's request stays asserted until that port is granted. It drops the cycle after its grant because done_q[i] is then set.
- all_done = &(done_q | (tcdm_req_o & tcdm_gnt_i) | skip).
- wide_gnt_o = wide_req_i & credit_ok & all_done. This is combinational and lands in the same cycle as the last outstanding narrow grant.
- With zero skew, gnt has zero-cycle latency.
- On wide_gnt_o, done_q clears to 0. Otherwise done_q |= tcdm_req_o & tcdm_gnt_i.
- Skipped ports push a synthetic entry (data 0) into their FIFO on wide_gnt_o, in order with real responses.
- If every slice is skipped, wide_gnt_o is asserted on the first cycle credit_ok holds.
- Each FIFO[i] has depth RESP_DEPTH. It pushes on tcdm_r_valid_i[i] or on a synthetic push, never both in the same cycle.
- wide_r_valid_o = &(~fifo_empty). This is combinational from FIFO state, so there is at least one cycle from the last narrow r_valid.
- On wide_r_valid_o, all FIFOs pop in the same cycle. There is no back-pressure, so the wide side must accept.
- wide_r_data_o = concatenation of FIFO heads; it is 0 when wide_r_valid_o=0.
- outstanding_q: +1 on wide_gnt_o, -1 on wide_r_valid_o, unchanged if both occur. Range 0..RESP_DEPTH.
- At outstanding_q == RESP_DEPTH, new issue is fully stalled: no narrow requests and no wide grant.
- A partially granted transaction never exists when credit_ok is 0, because credit is only consumed at wide grant.
- Bounds: at most outstanding_q+1 <= RESP_DEPTH entries sit in any FIFO, so no overflow is possible. Push to a full FIFO is an assertion failure.
- Responses return in order per port.

Test Plan:
- Basic read: DW=128, MP=4, all tcdm_gnt_i tied 1, read at 0x1000 → tcdm_add_o = 0x1000/0x1004/0x1008/0x100C; wide_gnt_o same cycle; per-port r_valid one cycle later → wide_r_valid_o next cycle with the data slices concatenated in port order.
- Grant skew: ports 0,2 granted cycle 0, port 1 cycle 2, port 3 cycle 4 → tcdm_req_o = 4'b1010 in cycles 1–2, 4'b1000 in cycles 3–4; wide_gnt_o only in cycle 4; a single wide_r_valid_o pulse.
- Response skew: r_valid ports staggered over 3 cycles → exactly one wide_r_valid_o, one cycle after the last narrow r_valid, with correct data.
- Credit stall: RESP_DEPTH=2, withhold all r_valid, issue 3 reads → 2 wide grants; third request stalls with tcdm_req_o=0 and busy_o=1; one full response set → third grant the cycle after wide_r_valid_o.
- Zero-BE skip: write with be=16'h00F0 → only port 1 requests; wide_gnt_o on port 1's grant; wide_r_valid_o after port 1's r_valid alone.
- Async reset mid-transaction: done_q=4'b0011, outstanding_q=1 → all outputs 0 immediately; the next request starts clean.

Source files
------------

// File: rtl/redmule_tcdm_splitter.sv
// Wide-to-narrow TCDM splitter: issues one wide request on MP narrow ports,
// tolerating per-port grant skew and reassembling per-port responses in order.
module redmule_tcdm_splitter #(
  parameter int unsigned DW           = 256,
  parameter int unsigned MP           = 8,
  parameter int unsigned AW           = 32,
  parameter int unsigned RESP_DEPTH   = 2,
  parameter int unsigned SKIP_ZERO_BE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wide_req_i,
  output logic                  wide_gnt_o,
  input  logic [AW-1:0]         wide_add_i,
  input  logic                  wide_wen_i,
  input  logic [DW/8-1:0]       wide_be_i,
  input  logic [DW-1:0]         wide_data_i,
  output logic [DW-1:0]         wide_r_data_o,
  output logic                  wide_r_valid_o,
  output logic [MP-1:0]         tcdm_req_o,
  input  logic [MP-1:0]         tcdm_gnt_i,
  output logic [MP*AW-1:0]      tcdm_add_o,
  output logic [MP-1:0]         tcdm_wen_o,
  output logic [DW/8-1:0]       tcdm_be_o,
  output logic [DW-1:0]         tcdm_data_o,
  input  logic [DW-1:0]         tcdm_r_data_i,
  input  logic [MP-1:0]         tcdm_r_valid_i,
  output logic                  busy_o
);

  localparam int unsigned SW = DW / MP;
  localparam int unsigned BW = SW / 8;
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [MP-1:0] done_q, done_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [MP-1:0] skip;
  logic [MP-1:0] fifo_empty;
  logic [DW-1:0] fifo_heads;
  logic          credit_ok;
  logic          all_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    credit_ok = (outstanding_q < CW'(RESP_DEPTH));
    skip      = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      skip[i] = (SKIP_ZERO_BE != 0) && !wide_wen_i && (wide_be_i[i*BW +: BW] == '0);
    end
    tcdm_req_o = {MP{wide_req_i & credit_ok}} & ~done_q & ~skip;
    all_done   = &(done_q | (tcdm_req_o & tcdm_gnt_i) | skip);
    wide_gnt_o = wide_req_i & credit_ok & all_done;
  end

  always_comb begin
    tcdm_add_o = '0;
    for (int unsigned i = 0; i < MP; i++) begin
      tcdm_add_o[i*AW +: AW] = wide_add_i + AW'(i * BW);
    end
  end

  assign tcdm_wen_o  = {MP{wide_wen_i}};
  assign tcdm_be_o   = wide_be_i;
  assign tcdm_data_o = wide_data_i;

  assign wide_r_valid_o = &(~fifo_empty);
  assign wide_r_data_o  = wide_r_valid_o ? fifo_heads : '0;
  assign busy_o         = (outstanding_q != '0) | (|done_q);

  always_comb begin
    done_d = wide_gnt_o ? '0 : (done_q | (tcdm_req_o & tcdm_gnt_i));
    outstanding_d = outstanding_q;
    if (wide_gnt_o && !wide_r_valid_o) outstanding_d = outstanding_q + CW'(1);
    else if (!wide_gnt_o && wide_r_valid_o) outstanding_d = outstanding_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q        <= '0;
      outstanding_q <= '0;
    end else begin
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
    end
  end

  for (genvar g = 0; g < MP; g++) begin : g_port
    logic [SW-1:0] mem_q [RESP_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop;
    logic [SW-1:0] push_data;

    // Skipped slices get a synthetic zero entry at wide grant so every port
    // holds exactly one entry per wide transaction, keeping reassembly aligned.
    assign push      = tcdm_r_valid_i[g] | (wide_gnt_o & skip[g]);
    assign push_data = tcdm_r_valid_i[g] ? tcdm_r_data_i[g*SW +: SW] : '0;
    assign pop       = wide_r_valid_o;

    assign fifo_empty[g]           = (cnt_q == '0);
    assign fifo_heads[g*SW +: SW]  = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
        for (int unsigned k = 0; k < RESP_DEPTH; k++) mem_q[k] <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= push_data;
          wptr_q        <= ptr_inc(wptr_q);
        end
        if (pop) rptr_q <= ptr_inc(rptr_q);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_ni) begin
        assert (!(push && (cnt_q == CW'(RESP_DEPTH))))
          else $error("response FIFO %0d overflow", g);
        assert (!(tcdm_r_valid_i[g] && wide_gnt_o && skip[g]))
          else $error("port %0d real and synthetic push collide", g);
      end
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter with DW=128, MP=4, RESP_DEPTH=2.
module tb_redmule_tcdm_splitter;

  localparam int unsigned DW = 128;
  localparam int unsigned MP = 4;
  localparam int unsigned AW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wide_req;
  logic              wide_gnt;
  logic [AW-1:0]     wide_add;
  logic              wide_wen;
  logic [DW/8-1:0]   wide_be;
  logic [DW-1:0]     wide_data;
  logic [DW-1:0]     wide_r_data;
  logic              wide_r_valid;
  logic [MP-1:0]     tcdm_req;
  logic [MP-1:0]     tcdm_gnt;
  logic [MP*AW-1:0]  tcdm_add;
  logic [MP-1:0]     tcdm_wen;
  logic [DW/8-1:0]   tcdm_be;
  logic [DW-1:0]     tcdm_data;
  logic [DW-1:0]     tcdm_r_data;
  logic [MP-1:0]     tcdm_r_valid;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  redmule_tcdm_splitter #(
    .DW(DW), .MP(MP), .AW(AW), .RESP_DEPTH(2), .SKIP_ZERO_BE(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wide_req_i(wide_req), .wide_gnt_o(wide_gnt), .wide_add_i(wide_add),
    .wide_wen_i(wide_wen), .wide_be_i(wide_be), .wide_data_i(wide_data),
    .wide_r_data_o(wide_r_data), .wide_r_valid_o(wide_r_valid),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data),
    .tcdm_r_data_i(tcdm_r_data), .tcdm_r_valid_i(tcdm_r_valid),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wide_req = 1'b0; wide_add = '0; wide_wen = 1'b1;
    wide_be = '1; wide_data = '0; tcdm_gnt = 4'hF; tcdm_r_data = '0; tcdm_r_valid = '0;
    #2;
    chk("rst_tcdm_req", DW'(tcdm_req), DW'(4'h0));
    chk("rst_wide_gnt", DW'(wide_gnt), DW'(1'b0));
    chk("rst_r_valid",  DW'(wide_r_valid), DW'(1'b0));
    chk("rst_busy",     DW'(busy), DW'(1'b0));
    chk("rst_r_data",   wide_r_data, '0);
    cyc(); cyc(); rst_n = 1'b1;

    // Basic read, all grants tied high
    cyc(); wide_req = 1'b1; wide_add = 32'h1000; wide_wen = 1'b1; wide_be = '1;
    smp();
    chk("basic_req", DW'(tcdm_req), DW'(4'hF));
    chk("basic_add", tcdm_add, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
    chk("basic_wen", DW'(tcdm_wen), DW'(4'hF));
    chk("basic_gnt", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_req = 1'b0; tcdm_r_valid = 4'hF;
    tcdm_r_data = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    smp();
    chk("basic_rv_early", DW'(wide_r_valid), DW'(1'b0));
    chk("basic_busy", DW'(busy), DW'(1'b1));
    cyc(); tcdm_r_valid = '0;
    smp();
    chk("basic_rv", DW'(wide_r_valid), DW'(1'b1));
    chk("basic_rdata", wide_r_data, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
    cyc(); smp();
    chk("basic_rv_off", DW'(wide_r_valid), DW'(1'b0));
    chk("basic_idle", DW'(busy), DW'(1'b0));

    // Grant skew followed by response skew
    cyc(); wide_req = 1'b1; wide_add = 32'h0100; tcdm_gnt = 4'b0101;
    smp();
    chk("skew_c0_req", DW'(tcdm_req), DW'(4'hF));
    chk("skew_c0_gnt", DW'(wide_gnt), DW'(1'b0));
    cyc(); tcdm_gnt = 4'b0000;
    smp();
    chk("skew_c1_req", DW'(tcdm_req), DW'(4'b1010));
    chk("skew_c1_gnt", DW'(wide_gnt), DW'(1'b0));
    cyc(); tcdm_gnt = 4'b0010;
    smp();
    chk("skew_c2_req", DW'(tcdm_req), DW'(4'b1010));
    chk("skew_c2_gnt", DW'(wide_gnt), DW'(1'b0));
    cyc(); tcdm_gnt = 4'b0000;
    smp();
    chk("skew_c3_req", DW'(tcdm_req), DW'(4'b1000));
    chk("skew_c3_gnt", DW'(wide_gnt), DW'(1'b0));
    cyc(); tcdm_gnt = 4'b1000;
    smp();
    chk("skew_c4_req", DW'(tcdm_req), DW'(4'b1000));
    chk("skew_c4_gnt", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_req = 1'b0; tcdm_gnt = 4'hF; tcdm_r_valid = 4'b0001;
    tcdm_r_data = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
    smp();
    chk("rskew_c0_rv", DW'(wide_r_valid), DW'(1'b0));
    chk("rskew_c0_req", DW'(tcdm_req), DW'(4'h0));
    cyc(); tcdm_r_valid = 4'b0110;
    smp();
    chk("rskew_c1_rv", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_valid = 4'b1000;
    smp();
    chk("rskew_c2_rv", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_valid = '0; tcdm_r_data = '0;
    smp();
    chk("rskew_rv", DW'(wide_r_valid), DW'(1'b1));
    chk("rskew_rdata", wide_r_data, {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0});
    cyc(); smp();
    chk("rskew_single", DW'(wide_r_valid), DW'(1'b0));
    chk("rskew_idle", DW'(busy), DW'(1'b0));

    // Credit stall: two reads in flight, third waits for one response set
    cyc(); wide_req = 1'b1; wide_add = 32'h2000;
    smp();
    chk("cred_g1", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_add = 32'h3000;
    smp();
    chk("cred_g2", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_add = 32'h4000;
    smp();
    chk("cred_stall_req", DW'(tcdm_req), DW'(4'h0));
    chk("cred_stall_gnt", DW'(wide_gnt), DW'(1'b0));
    chk("cred_stall_busy", DW'(busy), DW'(1'b1));
    cyc(); tcdm_r_valid = 4'hF; tcdm_r_data = {4{32'h1111_2222}};
    smp();
    chk("cred_stall2_gnt", DW'(wide_gnt), DW'(1'b0));
    chk("cred_stall2_rv", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_valid = '0;
    smp();
    chk("cred_rvA", DW'(wide_r_valid), DW'(1'b1));
    chk("cred_rdataA", wide_r_data, {4{32'h1111_2222}});
    chk("cred_still_gnt", DW'(wide_gnt), DW'(1'b0));
    chk("cred_still_req", DW'(tcdm_req), DW'(4'h0));
    cyc();
    smp();
    chk("cred_g3", DW'(wide_gnt), DW'(1'b1));
    chk("cred_g3_req", DW'(tcdm_req), DW'(4'hF));
    chk("cred_g3_add0", DW'(tcdm_add[31:0]), DW'(32'h4000));
    chk("cred_g3_rv", DW'(wide_r_valid), DW'(1'b0));
    cyc(); wide_req = 1'b0; tcdm_r_valid = 4'hF; tcdm_r_data = {4{32'h3333_4444}};
    smp();
    chk("cred_rv_gap", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_data = {4{32'h5555_6666}};
    smp();
    chk("cred_rvB", DW'(wide_r_valid), DW'(1'b1));
    chk("cred_rdataB", wide_r_data, {4{32'h3333_4444}});
    cyc(); tcdm_r_valid = '0; tcdm_r_data = '0;
    smp();
    chk("cred_rvC", DW'(wide_r_valid), DW'(1'b1));
    chk("cred_rdataC", wide_r_data, {4{32'h5555_6666}});
    cyc(); smp();
    chk("cred_idle", DW'(busy), DW'(1'b0));

    // Zero-BE skip: only slice 1 enabled on a write
    cyc(); wide_req = 1'b1; wide_wen = 1'b0; wide_be = 16'h00F0; tcdm_gnt = 4'h0;
    wide_add = 32'h0800;
    wide_data = {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111};
    smp();
    chk("skip_req", DW'(tcdm_req), DW'(4'b0010));
    chk("skip_gnt_wait", DW'(wide_gnt), DW'(1'b0));
    chk("skip_wdata1", DW'(tcdm_data[63:32]), DW'(32'hCAFE_F00D));
    chk("skip_be1", DW'(tcdm_be[7:4]), DW'(4'hF));
    chk("skip_wen", DW'(tcdm_wen), DW'(4'h0));
    cyc(); tcdm_gnt = 4'b0010;
    smp();
    chk("skip_gnt", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_req = 1'b0; tcdm_gnt = 4'hF; tcdm_r_valid = 4'b0010;
    tcdm_r_data = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'h0000_BEEF, 32'hDDDD_DDDD};
    smp();
    chk("skip_rv_early", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_valid = '0;
    smp();
    chk("skip_rv", DW'(wide_r_valid), DW'(1'b1));
    chk("skip_rdata", wide_r_data, {32'h0, 32'h0, 32'h0000_BEEF, 32'h0});
    cyc(); smp();
    chk("skip_rv_off", DW'(wide_r_valid), DW'(1'b0));

    // All slices skipped: grant with no narrow traffic
    cyc(); wide_req = 1'b1; wide_be = '0;
    smp();
    chk("allskip_req", DW'(tcdm_req), DW'(4'h0));
    chk("allskip_gnt", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_req = 1'b0; wide_wen = 1'b1; wide_be = '1; tcdm_r_data = '1;
    smp();
    chk("allskip_rv", DW'(wide_r_valid), DW'(1'b1));
    chk("allskip_rdata", wide_r_data, '0);
    cyc(); tcdm_r_data = '0;
    smp();
    chk("allskip_idle", DW'(busy), DW'(1'b0));

    // Async reset with done_q=0011 and one read outstanding
    cyc(); wide_req = 1'b1; wide_add = 32'h6000;
    smp();
    chk("rstx_g1", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_add = 32'h7000; tcdm_gnt = 4'b0011;
    smp();
    chk("rstx_part_gnt", DW'(wide_gnt), DW'(1'b0));
    cyc(); tcdm_gnt = 4'h0;
    smp();
    chk("rstx_part_req", DW'(tcdm_req), DW'(4'b1100));
    chk("rstx_busy", DW'(busy), DW'(1'b1));
    rst_n = 1'b0; wide_req = 1'b0;
    #1;
    chk("rstx_req0", DW'(tcdm_req), DW'(4'h0));
    chk("rstx_gnt0", DW'(wide_gnt), DW'(1'b0));
    chk("rstx_rv0", DW'(wide_r_valid), DW'(1'b0));
    chk("rstx_busy0", DW'(busy), DW'(1'b0));
    chk("rstx_rdata0", wide_r_data, '0);
    cyc(); cyc(); rst_n = 1'b1;
    cyc(); wide_req = 1'b1; wide_add = 32'h5000; tcdm_gnt = 4'hF;
    smp();
    chk("post_req", DW'(tcdm_req), DW'(4'hF));
    chk("post_gnt", DW'(wide_gnt), DW'(1'b1));
    cyc(); wide_req = 1'b0; tcdm_r_valid = 4'hF;
    tcdm_r_data = {32'h0B0B_0003, 32'h0B0B_0002, 32'h0B0B_0001, 32'h0B0B_0000};
    smp();
    chk("post_rv_early", DW'(wide_r_valid), DW'(1'b0));
    cyc(); tcdm_r_valid = '0;
    smp();
    chk("post_rv", DW'(wide_r_valid), DW'(1'b1));
    chk("post_rdata", wide_r_data, {32'h0B0B_0003, 32'h0B0B_0002, 32'h0B0B_0001, 32'h0B0B_0000});
    cyc(); smp();
    chk("post_idle", DW'(busy), DW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
